// File: rtl/sap_pkg.sv
// Shared SAP program-memory constants, loader state encoding and opcodes used to build images.
package sap_pkg;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 9;
  localparam int unsigned DEPTH  = 16;

  localparam logic [DATA_W-1:0] FILL_WORD = 9'h1FF;

  typedef logic [2:0] loader_state_t;
  localparam loader_state_t StIdle  = 3'd0;
  localparam loader_state_t StLoad  = 3'd1;
  localparam loader_state_t StCheck = 3'd2;
  localparam loader_state_t StFill  = 3'd3;
  localparam loader_state_t StRun   = 3'd4;
  localparam loader_state_t StErr   = 3'd5;

  localparam logic [3:0] LDA = 4'h0;
  localparam logic [3:0] ADD = 4'h1;
  localparam logic [3:0] SUB = 4'h2;
  localparam logic [3:0] OUT = 4'h3;

  function automatic logic [DATA_W-1:0] make_word(logic [3:0] opcode, logic [4:0] operand);
    return {opcode, operand};
  endfunction

endpackage

// File: rtl/sap_program_loader_if.sv
// Host stream, CPU read port and status signals of the SAP program loader.
interface sap_program_loader_if;
  import sap_pkg::*;

  logic              start;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              in_ready;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ce_n;
  logic [DATA_W-1:0] rd_data;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   word_count;

  modport master (
    output start, in_valid, in_data, in_last, rd_addr, rd_ce_n,
    input  in_ready, rd_data, cpu_hold, busy, done, error, word_count
  );

  modport slave (
    input  start, in_valid, in_data, in_last, rd_addr, rd_ce_n,
    output in_ready, rd_data, cpu_hold, busy, done, error, word_count
  );

endinterface

// File: rtl/sap_prog_ram.sv
// DEPTH x DATA_W program RAM: synchronous write, asynchronous read gated by active-low CE.
module sap_prog_ram #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 9,
  parameter int unsigned DEPTH  = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  input  logic              ce_n,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = ce_n ? '0 : mem[raddr];

endmodule

// File: rtl/sap_program_loader.sv
// SAP program loader: streams an image into program RAM, pads it, then releases the CPU.
// Optional checksum word after the image is enabled with LOADER_CHECKSUM_EN.
module sap_program_loader #(
  parameter int unsigned       ADDR_W    = sap_pkg::ADDR_W,
  parameter int unsigned       DATA_W    = sap_pkg::DATA_W,
  parameter int unsigned       DEPTH     = sap_pkg::DEPTH,
  parameter logic [DATA_W-1:0] FILL_WORD = sap_pkg::FILL_WORD
) (
  input logic                 clk,
  input logic                 rst,
  sap_program_loader_if.slave bus
);
  import sap_pkg::*;

  localparam logic [ADDR_W-1:0] LastAddr  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   FullCount = (ADDR_W + 1)'(DEPTH);

  loader_state_t     state_q, state_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              cpu_hold_q;
  logic              in_ready;
  logic              xfer;
  logic              we;
  logic [DATA_W-1:0] wdata;
`ifdef LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q, sum_d;
`endif

  assign in_ready = (state_q == StLoad) || (state_q == StCheck);
  assign xfer     = bus.in_valid && in_ready;

  always_comb begin
    state_d   = state_q;
    wr_addr_d = wr_addr_q;
    count_d   = count_q;
    we        = 1'b0;
    wdata     = bus.in_data;
`ifdef LOADER_CHECKSUM_EN
    sum_d     = sum_q;
`endif
    case (state_q)
      StIdle, StRun, StErr: begin
        if (bus.start) begin
          state_d   = StLoad;
          wr_addr_d = '0;
          count_d   = '0;
`ifdef LOADER_CHECKSUM_EN
          sum_d     = '0;
`endif
        end
      end
      StLoad: begin
        if (xfer) begin
          we        = 1'b1;
          wr_addr_d = wr_addr_q + 1'b1;
          count_d   = (count_q == FullCount) ? count_q : count_q + 1'b1;
`ifdef LOADER_CHECKSUM_EN
          sum_d     = sum_q + bus.in_data;
          if (bus.in_last || wr_addr_q == LastAddr) begin
            state_d = StCheck;
          end
`else
          if (bus.in_last || wr_addr_q == LastAddr) begin
            state_d = (wr_addr_q == LastAddr) ? StRun : StFill;
          end
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      StCheck: begin
        // The checksum word is compared only; it is never written to RAM.
        if (xfer) begin
          if (bus.in_data != sum_q) begin
            state_d = StErr;
          end else begin
            state_d = (count_q == FullCount) ? StRun : StFill;
          end
        end
      end
`endif
      StFill: begin
        we        = 1'b1;
        wdata     = FILL_WORD;
        wr_addr_d = wr_addr_q + 1'b1;
        if (wr_addr_q == LastAddr) begin
          state_d = StRun;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      wr_addr_q  <= '0;
      count_q    <= '0;
      cpu_hold_q <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      wr_addr_q  <= wr_addr_d;
      count_q    <= count_d;
      // Registered from the next state so the CPU is released on the edge of the final write.
      cpu_hold_q <= (state_d != StRun);
`ifdef LOADER_CHECKSUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

  sap_prog_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (wr_addr_q),
    .wdata (wdata),
    .raddr (bus.rd_addr),
    .ce_n  (bus.rd_ce_n | cpu_hold_q),
    .rdata (bus.rd_data)
  );

  assign bus.in_ready   = in_ready;
  assign bus.cpu_hold   = cpu_hold_q;
  assign bus.busy       = (state_q == StLoad) || (state_q == StCheck) || (state_q == StFill);
  assign bus.done       = (state_q == StRun);
  assign bus.word_count = count_q;
`ifdef LOADER_CHECKSUM_EN
  assign bus.error      = (state_q == StErr);
`else
  assign bus.error      = 1'b0;
`endif

endmodule

// File: doc/sap_program_loader.md
Name: sap_program_loader

Overview:
- Writer side of the SAP program memory: receives program words over a valid/ready stream and writes them into an owned 16x9 RAM.
- Exposes an active-low-CE asynchronous read port to the CPU's MAR/SRAM path.
- Holds the CPU in reset through `cpu_hold` until the image is complete, then releases it.
- Replaces the hard-coded SRAM initialisation; the CPU becomes reloadable at run time.

Parameters:
- `ADDR_W`, 4, program memory address width.
- `DATA_W`, 9, program word width: opcode[8:5], operand[4:0].
- `DEPTH`, 16, number of memory words; must equal 2**`ADDR_W`.
- `FILL_WORD`, 9'h1FF, value written to locations not supplied by the host.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle pulse that begins a load.
- `in_valid` in 1: host word valid.
- `in_data` in `DATA_W`: host word.
- `in_last` in 1: qualifies `in_data` as the final program word.
- `in_ready` out 1: loader accepts a word this cycle.
- `rd_addr` in `ADDR_W`: CPU read address (MAR output).
- `rd_ce_n` in 1: CPU chip enable, active-low.
- `rd_data` out `DATA_W`: CPU read data.
- `cpu_hold` out 1: drives the CPU `rst`; high means the CPU is held.
- `busy` out 1: load in progress.
- `done` out 1: image complete, CPU running.
- `error` out 1: checksum failure (only with the optional feature).
- `word_count` out `ADDR_W`+1: words accepted from the host, 0..16.

Behaviour:
- Reset values: state IDLE, `wr_addr`=0, `word_count`=0, `in_ready`=0, `cpu_hold`=1, `busy`=0, `done`=0, `error`=0.
- RAM contents are not reset.
- States: IDLE, LOAD, CHECK (feature only), FILL, RUN, ERR.
- IDLE: `start`=1 -> LOAD next cycle; clears `wr_addr`, `word_count` and `error`.
- LOAD: `in_ready`=1, `busy`=1. A transfer occurs on a rising edge with `in_valid`&`in_ready`: mem[`wr_addr`] <= `in_data`; `wr_addr`++; `word_count`++.
- LOAD exit on a transfer with `in_last`=1, or on the transfer at `wr_addr`=`DEPTH`-1 (regardless of `in_last`):
  - CHECK if the feature is enabled;
  - otherwise FILL if `wr_addr`+1 < `DEPTH`;
  - otherwise RUN.
- FILL: `in_ready`=0; writes `FILL_WORD` at one address per cycle until address `DEPTH`-1 is written, then RUN. Fill latency is `DEPTH`-`word_count` cycles.
- RUN: `cpu_hold`=0, `done`=1, `busy`=0, `in_ready`=0.
  - `start` -> LOAD next cycle with `cpu_hold`=1 and `done`=0.
  - The CPU restarts from PC 0 when released.
- `start` while in LOAD, CHECK or FILL is ignored.
- `in_valid` outside LOAD/CHECK is ignored; no write occurs.
- Read port: `rd_data` = (~`rd_ce_n` && !`cpu_hold`) ? mem[`rd_addr`] : 0. The read is combinational.
- Write port: synchronous, a single port owned by the FSM. No read/write collision is possible because the CPU is held during writes.
- `cpu_hold` is registered and glitch-free. It deasserts one cycle after the final write, so the first CPU fetch sees the complete image.
- `rst` mid-load: the FSM returns to IDLE and the CPU is held. Partial RAM contents remain but are irrelevant until a new load completes.
- `word_count` saturates at `DEPTH`.

Optional Feature:
- Macro: `LOADER_CHECKSUM_EN`.
- Enabled:
  - The loader accumulates a `DATA_W`-bit wrapping sum of accepted words during LOAD.
  - After the last word it enters CHECK with `in_ready`=1 and accepts exactly one extra word as the checksum; `in_last` is ignored there.
  - Checksum word equals the sum -> FILL/RUN exactly as without the feature.
  - Mismatch -> ERR: `error`=1, `cpu_hold`=1, `busy`=0, `done`=0. ERR exits only via `start` (-> LOAD) or `rst`.
- Disabled: no CHECK/ERR states, no accumulator; `error` is tied to 0.

Decomposition:
- Shared package `sap_pkg`:
  - `ADDR_W`/`DATA_W`/`DEPTH` constants;
  - `FILL_WORD`;
  - the loader state enum;
  - opcode constants LDA=4'h0, ADD=4'h1, SUB=4'h2, OUT=4'h3, used by benches to build images.
- One sub-module, `sap_prog_ram`: DEPTH x DATA_W array, synchronous write, asynchronous active-low-CE read with zero output when disabled.
- FSM, address counter and checksum live in the top.

Test Plan:
- Load the standard program, with `in_last` on word 11 (addr 11):
  - Words: 000001001, 000101010, 001001011, 0011xxxxx→001100000, 1FF×5, 001, 006, 003.
  - Required: 4 FILL cycles write 1FF at addrs 12..15; `done`=1, `cpu_hold`=0.
  - Reads: addr 9 -> 001, addr 10 -> 006, addr 14 -> 1FF.
- Backpressure: 16 words with `in_valid` toggling every other cycle, no `in_last` -> `word_count`=16, no FILL, RUN the cycle after the 16th transfer.
- Assert `rst` after 5 words accepted -> IDLE, `cpu_hold`=1, `in_ready`=0; then `start` with a fresh load -> `word_count` restarts at 0.
- Pulse `start` during LOAD -> ignored, `word_count` unchanged; `start` in RUN -> `cpu_hold` rises next cycle and `rd_data`=0.
- `rd_ce_n`=1 in RUN -> `rd_data`=0; `rd_ce_n`=0 with `cpu_hold`=1 -> `rd_data`=0.
- `LOADER_CHECKSUM_EN`, words 001, 006, 003 (`in_last` on 003):
  - Checksum 00A -> RUN.
  - Checksum 00B -> ERR, `error`=1, `cpu_hold`=1; `start` clears `error`.
